// File: rtl/inst_decode_stage.sv
// Decode stage for a single-issue MIPS subset. One instruction word and its PC
// are accepted per valid/ready handshake. The split fields and decoded controls
// are registered for the execute/register-file stage. Two wrapping counters
// track accepted and illegal words for debug display.
module inst_decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      inst_code_i,
  input  logic [31:0]      pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [4:0]       rs_o,
  output logic [4:0]       rt_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       shamt_o,
  output logic [4:0]       w_addr_o,
  output logic [31:0]      imm32_o,
  output logic [31:0]      j_target_o,
  output logic [2:0]       alu_op_o,
  output logic             reg_write_o,
  output logic             mem_write_o,
  output logic             mem_read_o,
  output logic             use_imm_o,
  output logic [1:0]       branch_o,
  output logic             jump_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] inst_cnt_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                         OP_ORI   = 6'b001101, OP_XORI = 6'b001110, OP_SLTIU = 6'b001011,
                         OP_LW    = 6'b100011, OP_SW   = 6'b101011, OP_BEQ  = 6'b000100,
                         OP_BNE   = 6'b000101, OP_J    = 6'b000010, OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND  = 6'b100100,
                         FN_OR  = 6'b100101, FN_XOR = 6'b100110, FN_NOR  = 6'b100111,
                         FN_SLTU = 6'b101011, FN_SLLV = 6'b000100;

  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_XOR  = 3'b010, ALU_NOR = 3'b011,
                         ALU_ADD = 3'b100, ALU_SUB = 3'b101, ALU_SLTU = 3'b110, ALU_SLL = 3'b111;

  state_t      state_q, state_d;
  logic        accept;
  logic [5:0]  opcode, funct;
  logic [31:0] pc_plus4;

  // decoded next values
  logic [2:0]  alu_op_d;
  logic        wr_raw, mem_write_d, mem_read_d, use_imm_d, jump_d, illegal_d, zero_ext;
  logic [1:0]  branch_d;
  logic [4:0]  w_addr_d;
  logic        reg_write_d;
  logic [31:0] imm32_d, j_target_d;

  assign opcode      = inst_code_i[31:26];
  assign funct       = inst_code_i[5:0];
  assign pc_plus4    = pc_i + 32'd4;
  assign out_valid_o = (state_q == FULL);
  // A held word can only be replaced when downstream takes it this cycle.
  assign in_ready_o  = (state_q == EMPTY) || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;

  // Output-register occupancy state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Fill on accept; drain on consume with no replacement word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready_i && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Opcode/funct decode into control signals; unknown encodings leave all controls at 0.
  always_comb begin
    alu_op_d    = ALU_AND;
    wr_raw      = 1'b0;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    use_imm_d   = 1'b0;
    branch_d    = 2'b00;
    jump_d      = 1'b0;
    illegal_d   = 1'b0;
    zero_ext    = 1'b0;
    w_addr_d    = 5'd0;
    case (opcode)
      OP_RTYPE: begin
        wr_raw   = 1'b1;
        w_addr_d = inst_code_i[15:11];
        case (funct)
          FN_ADD:  alu_op_d = ALU_ADD;
          FN_SUB:  alu_op_d = ALU_SUB;
          FN_AND:  alu_op_d = ALU_AND;
          FN_OR:   alu_op_d = ALU_OR;
          FN_XOR:  alu_op_d = ALU_XOR;
          FN_NOR:  alu_op_d = ALU_NOR;
          FN_SLTU: alu_op_d = ALU_SLTU;
          FN_SLLV: alu_op_d = ALU_SLL;
          default: begin
            illegal_d = 1'b1;
            wr_raw    = 1'b0;
            w_addr_d  = 5'd0;
          end
        endcase
      end
      OP_ADDI:  begin alu_op_d = ALU_ADD;  wr_raw = 1'b1; use_imm_d = 1'b1; w_addr_d = inst_code_i[20:16]; end
      OP_ANDI:  begin alu_op_d = ALU_AND;  wr_raw = 1'b1; use_imm_d = 1'b1; w_addr_d = inst_code_i[20:16]; zero_ext = 1'b1; end
      OP_ORI:   begin alu_op_d = ALU_OR;   wr_raw = 1'b1; use_imm_d = 1'b1; w_addr_d = inst_code_i[20:16]; zero_ext = 1'b1; end
      OP_XORI:  begin alu_op_d = ALU_XOR;  wr_raw = 1'b1; use_imm_d = 1'b1; w_addr_d = inst_code_i[20:16]; zero_ext = 1'b1; end
      OP_SLTIU: begin alu_op_d = ALU_SLTU; wr_raw = 1'b1; use_imm_d = 1'b1; w_addr_d = inst_code_i[20:16]; end
      OP_LW:    begin alu_op_d = ALU_ADD;  wr_raw = 1'b1; use_imm_d = 1'b1; w_addr_d = inst_code_i[20:16]; mem_read_d = 1'b1; end
      OP_SW:    begin alu_op_d = ALU_ADD;  use_imm_d = 1'b1; mem_write_d = 1'b1; end
      OP_BEQ:   begin alu_op_d = ALU_SUB;  branch_d = 2'b01; end
      OP_BNE:   begin alu_op_d = ALU_SUB;  branch_d = 2'b10; end
      OP_J:     begin jump_d = 1'b1; end
      OP_JAL:   begin jump_d = 1'b1; wr_raw = 1'b1; w_addr_d = 5'd31; end
      default:  illegal_d = 1'b1;
    endcase
  end

  // $0 is hardwired, so a write to it is suppressed at the source.
  assign reg_write_d = wr_raw && (w_addr_d != 5'd0);
  assign imm32_d     = zero_ext ? {16'h0000, inst_code_i[15:0]}
                                : {{16{inst_code_i[15]}}, inst_code_i[15:0]};
  assign j_target_d  = {pc_plus4[31:28], inst_code_i[25:0], 2'b00};

  // Decoded output register; loads only on accept so a stalled word stays frozen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rs_o <= '0; rt_o <= '0; rd_o <= '0; shamt_o <= '0; w_addr_o <= '0;
      imm32_o <= '0; j_target_o <= '0; alu_op_o <= '0; reg_write_o <= 1'b0;
      mem_write_o <= 1'b0; mem_read_o <= 1'b0; use_imm_o <= 1'b0; branch_o <= '0;
      jump_o <= 1'b0; illegal_o <= 1'b0;
    end else if (accept) begin
      rs_o        <= inst_code_i[25:21];
      rt_o        <= inst_code_i[20:16];
      rd_o        <= inst_code_i[15:11];
      shamt_o     <= inst_code_i[10:6];
      w_addr_o    <= w_addr_d;
      imm32_o     <= imm32_d;
      j_target_o  <= j_target_d;
      alu_op_o    <= alu_op_d;
      reg_write_o <= reg_write_d;
      mem_write_o <= mem_write_d;
      mem_read_o  <= mem_read_d;
      use_imm_o   <= use_imm_d;
      branch_o    <= branch_d;
      jump_o      <= jump_d;
      illegal_o   <= illegal_d;
    end
  end

  // Debug counters of accepted and illegal words, free-running with wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inst_cnt_o    <= '0;
      illegal_cnt_o <= '0;
    end else if (accept) begin
      inst_cnt_o <= inst_cnt_o + CNT_W'(1);
      if (illegal_d) illegal_cnt_o <= illegal_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: reference decoder plus handshake model checked
// every falling edge, and directed vectors with hand-computed expectations.
module tb_inst_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i, out_ready_i;
  logic [31:0] inst_code_i, pc_i;
  logic        in_ready_o, out_valid_o;
  logic [4:0]  rs_o, rt_o, rd_o, shamt_o, w_addr_o;
  logic [31:0] imm32_o, j_target_o;
  logic [2:0]  alu_op_o;
  logic        reg_write_o, mem_write_o, mem_read_o, use_imm_o, jump_o, illegal_o;
  logic [1:0]  branch_o;
  logic [15:0] inst_cnt_o, illegal_cnt_o;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  inst_decode_stage #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_code_i(inst_code_i), .pc_i(pc_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .shamt_o(shamt_o), .w_addr_o(w_addr_o),
    .imm32_o(imm32_o), .j_target_o(j_target_o), .alu_op_o(alu_op_o), .reg_write_o(reg_write_o),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .use_imm_o(use_imm_o),
    .branch_o(branch_o), .jump_o(jump_o), .illegal_o(illegal_o),
    .inst_cnt_o(inst_cnt_o), .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  rs, rt, rd, shamt, w_addr;
    logic [31:0] imm32, j_target;
    logic [2:0]  alu_op;
    logic        reg_write, mem_write, mem_read, use_imm;
    logic [1:0]  branch;
    logic        jump, illegal;
  } dec_t;

  // Reference decode written from the instruction-set table, by instruction class.
  function automatic dec_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    dec_t d;
    int   op, fn, alu, cls;   // cls: 0 illegal, 1 R, 2 I-alu, 3 lw, 4 sw, 5 branch, 6 j, 7 jal
    bit   zext;
    d = '0;
    op = int'(w[31:26]); fn = int'(w[5:0]);
    alu = 0; cls = 0; zext = 1'b0;
    d.rs = w[25:21]; d.rt = w[20:16]; d.rd = w[15:11]; d.shamt = w[10:6];
    if (op == 0) begin
      cls = 1;
      case (fn)
        32: alu = 4; 34: alu = 5; 36: alu = 0; 37: alu = 1;
        38: alu = 2; 39: alu = 3; 43: alu = 6; 4:  alu = 7;
        default: cls = 0;
      endcase
    end else begin
      case (op)
        8:  begin cls = 2; alu = 4; end
        12: begin cls = 2; alu = 0; zext = 1'b1; end
        13: begin cls = 2; alu = 1; zext = 1'b1; end
        14: begin cls = 2; alu = 2; zext = 1'b1; end
        11: begin cls = 2; alu = 6; end
        35: begin cls = 3; alu = 4; end
        43: begin cls = 4; alu = 4; end
        4, 5: begin cls = 5; alu = 5; end
        2:  cls = 6;
        3:  cls = 7;
        default: cls = 0;
      endcase
    end
    d.imm32 = {16'h0000, w[15:0]};
    if (!zext && w[15]) d.imm32 = d.imm32 - 32'h0001_0000;
    d.j_target = ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, w[25:0]} * 32'd4);
    d.alu_op = 3'(alu);
    d.illegal = (cls == 0);
    d.use_imm = (cls >= 2 && cls <= 4);
    d.mem_read = (cls == 3);
    d.mem_write = (cls == 4);
    d.branch = (cls == 5) ? ((op == 4) ? 2'b01 : 2'b10) : 2'b00;
    d.jump = (cls == 6 || cls == 7);
    d.w_addr = (cls == 1) ? w[15:11] : (cls == 2 || cls == 3) ? w[20:16] : (cls == 7) ? 5'd31 : 5'd0;
    d.reg_write = (cls == 1 || cls == 2 || cls == 3 || cls == 7) && (d.w_addr != 5'd0);
    return d;
  endfunction

  // Handshake/occupancy model.
  dec_t        m_dec = '0;
  logic        m_valid = 1'b0;
  logic [15:0] m_cnt = '0, m_ill = '0;
  dec_t        nxt_dec;
  assign nxt_dec = ref_decode(inst_code_i, pc_i);

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid <= 1'b0; m_dec <= '0; m_cnt <= '0; m_ill <= '0;
    end else if (in_valid_i && (!m_valid || out_ready_i)) begin
      m_dec   <= nxt_dec;
      m_valid <= 1'b1;
      m_cnt   <= m_cnt + 16'd1;
      if (nxt_dec.illegal) m_ill <= m_ill + 16'd1;
    end else if (m_valid && out_ready_i) begin
      m_valid <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("out_valid", 32'(out_valid_o), 32'(m_valid));
      check("in_ready", 32'(in_ready_o), 32'(!m_valid || out_ready_i));
      check("inst_cnt", 32'(inst_cnt_o), 32'(m_cnt));
      check("illegal_cnt", 32'(illegal_cnt_o), 32'(m_ill));
      check("fields", {12'd0, rs_o, rt_o, rd_o, shamt_o}, {12'd0, m_dec.rs, m_dec.rt, m_dec.rd, m_dec.shamt});
      check("w_addr", 32'(w_addr_o), 32'(m_dec.w_addr));
      check("imm32", imm32_o, m_dec.imm32);
      check("j_target", j_target_o, m_dec.j_target);
      check("ctrl", {21'd0, alu_op_o, reg_write_o, mem_write_o, mem_read_o, use_imm_o, branch_o, jump_o, illegal_o},
            {21'd0, m_dec.alu_op, m_dec.reg_write, m_dec.mem_write, m_dec.mem_read, m_dec.use_imm,
             m_dec.branch, m_dec.jump, m_dec.illegal});
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    in_valid_i = 1'b1; inst_code_i = w; pc_i = pc;
    step();
    $display("[TB] accepted inst=0x%08h pc=0x%08h cnt=%0d", w, pc, inst_cnt_o);
  endtask

  localparam int NEXTRA = 4;
  logic [31:0] extra_w  [NEXTRA] = '{32'h0C000001, 32'h10220003, 32'h00220020, 32'h0022183F};
  logic [31:0] extra_pc [NEXTRA] = '{32'hFFFFFFFC, 32'h00000100, 32'h00000104, 32'h00000108};
  logic [31:0] stream_w [8] = '{32'h00221820, 32'h2005FFFF, 32'h3405FFFF, 32'h8C430004,
                                32'hAC220008, 32'h14220002, 32'h00632027, 32'h3866000F};

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1; inst_code_i = '0; pc_i = '0;
    step(); step();
    rst_i = 1'b0;
    cmp_en = 1'b1;
    check("reset out_valid", 32'(out_valid_o), 32'd0);
    check("reset in_ready", 32'(in_ready_o), 32'd1);
    step();

    // add $3,$1,$2
    send(32'h00221820, 32'h0);
    in_valid_i = 1'b0;
    check("add valid", 32'(out_valid_o), 32'd1);
    check("add rs/rt/rd", {17'd0, rs_o, rt_o, rd_o}, {17'd0, 5'd1, 5'd2, 5'd3});
    check("add w_addr", 32'(w_addr_o), 32'd3);
    check("add alu", 32'(alu_op_o), 32'd4);
    check("add regw/imm", {30'd0, reg_write_o, use_imm_o}, 32'b10);
    check("add cnt", 32'(inst_cnt_o), 32'd1);

    // addi sign-extend, ori zero-extend
    send(32'h2005FFFF, 32'h4);
    check("addi imm", imm32_o, 32'hFFFFFFFF);
    check("addi alu", 32'(alu_op_o), 32'd4);
    send(32'h3405FFFF, 32'h8);
    check("ori imm", imm32_o, 32'h0000FFFF);
    check("ori alu", 32'(alu_op_o), 32'd1);
    in_valid_i = 1'b0;
    step();

    // sw stalled for three cycles with the next word waiting
    out_ready_i = 1'b0;
    send(32'hAC220008, 32'hC);
    inst_code_i = 32'h00221820; pc_i = 32'h10;
    for (int i = 0; i < 3; i++) begin
      check("stall in_ready", 32'(in_ready_o), 32'd0);
      check("stall sw ctrl", {30'd0, mem_write_o, reg_write_o}, 32'b10);
      check("stall imm", imm32_o, 32'h8);
      check("stall cnt", 32'(inst_cnt_o), 32'd4);
      step();
    end
    out_ready_i = 1'b1;
    #1;
    check("release in_ready", 32'(in_ready_o), 32'd1);
    step();
    check("after stall mem_write", 32'(mem_write_o), 32'd0);
    check("after stall cnt", 32'(inst_cnt_o), 32'd5);
    in_valid_i = 1'b0;
    step();

    // j, then illegal opcode
    send(32'h08000010, 32'h00000040);
    check("j target", j_target_o, 32'h00000040);
    check("j jump/regw", {30'd0, jump_o, reg_write_o}, 32'b10);
    send(32'hFC000000, 32'h00000044);
    check("illegal flag", 32'(illegal_o), 32'd1);
    check("illegal ctrl", {24'd0, reg_write_o, mem_write_o, mem_read_o, branch_o, jump_o, alu_op_o[1:0]}, 32'd0);
    check("illegal alu", 32'(alu_op_o), 32'd0);
    check("illegal cnt", 32'(illegal_cnt_o), 32'd1);

    // jal with PC wrap, beq, write to $0, unsupported funct
    send(extra_w[0], extra_pc[0]);
    check("jal target wrap", j_target_o, 32'h00000004);
    check("jal w_addr", 32'(w_addr_o), 32'd31);
    check("jal regw", 32'(reg_write_o), 32'd1);
    send(extra_w[1], extra_pc[1]);
    check("beq branch", 32'(branch_o), 32'd1);
    check("beq alu", 32'(alu_op_o), 32'd5);
    send(extra_w[2], extra_pc[2]);
    check("add $0 regw", 32'(reg_write_o), 32'd0);
    send(extra_w[3], extra_pc[3]);
    check("bad funct illegal", 32'(illegal_o), 32'd1);
    check("bad funct ill cnt", 32'(illegal_cnt_o), 32'd2);

    // hold the last word, then async reset mid-cycle
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    step();
    #2 rst_i = 1'b1;
    #1;
    check("async rst out_valid", 32'(out_valid_o), 32'd0);
    check("async rst in_ready", 32'(in_ready_o), 32'd1);
    check("async rst cnts", {inst_cnt_o, illegal_cnt_o}, 32'd0);
    rst_i = 1'b0; out_ready_i = 1'b1;
    step();

    // back-to-back stream, one output per cycle
    for (int i = 0; i < 8; i++) begin
      send(stream_w[i], 32'(i * 4));
      check("stream valid", 32'(out_valid_o), 32'd1);
      check("stream cnt", 32'(inst_cnt_o), 32'(i + 1));
    end

    // run the counter up to its top value, then wrap
    in_valid_i = 1'b1; inst_code_i = 32'h00221820; pc_i = 32'h0;
    for (int k = 8; k < 65535; k++) step();
    check("cnt top", 32'(inst_cnt_o), 32'h0000FFFF);
    step();
    $display("[TB] wrap accept cnt=%0d", inst_cnt_o);
    check("cnt wrap", 32'(inst_cnt_o), 32'd0);
    in_valid_i = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
